// File: rtl/traffic_vga_pkg.sv
// -----------------------------------------------------------------------------
// traffic_vga_pkg
// Shared constants and types for the traffic-light VGA renderer.
//   - 640x480@60 VGA timing (active, front porch, sync, back porch, totals)
//   - Lamp geometry: left x, top y of lamp 0, edge length, vertical gap, outline
//   - color_t and the named lamp colours
//   - lamp_top(): top row of lamp idx, built from adds only so that it folds
//     to a constant wherever it is used to size a localparam
// -----------------------------------------------------------------------------
package traffic_vga_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] SQ_X0    = 10'd270;
    localparam logic [9:0] SQ_Y0    = 10'd60;
    localparam logic [9:0] SQ_SIZE  = 10'd100;
    localparam logic [9:0] SQ_GAP   = 10'd20;
    localparam logic [9:0] BORDER   = 10'd2;

    typedef logic [2:0] color_t;   // {r,g,b}

    localparam color_t C_BLACK  = 3'b000;
    localparam color_t C_WHITE  = 3'b111;
    localparam color_t C_RED    = 3'b100;
    localparam color_t C_YELLOW = 3'b110;
    localparam color_t C_GREEN  = 3'b010;

    function automatic logic [9:0] lamp_top(input logic [1:0] idx,
                                            input logic [9:0] y0,
                                            input logic [9:0] size,
                                            input logic [9:0] gap);
        logic [9:0] pitch;
        pitch = size + gap;
        case (idx)
            2'd0:    return y0;
            2'd1:    return y0 + pitch;
            default: return y0 + pitch + pitch;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Free-running raster counters with combinational sync/visible decode.
// Ports:
//   pixelclk   in   pixel clock
//   rst        in   synchronous active-high reset, counters to (0,0)
//   hcnt       out  horizontal position 0..H_TOTAL-1
//   vcnt       out  vertical position 0..V_TOTAL-1
//   hsync_n    out  horizontal sync for the current position, active low
//   vsync_n    out  vertical sync for the current position, active low
//   visible    out  current position lies in the active area
//   frame_end  out  current position is the last one of the frame
// Timing defaults to 640x480@60; the parameters exist so the raster can be
// scaled without touching the logic.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import traffic_vga_pkg::*;
#(
    parameter logic [9:0] P_H_ACTIVE = H_ACTIVE,
    parameter logic [9:0] P_H_FP     = H_FP,
    parameter logic [9:0] P_H_SYNC   = H_SYNC,
    parameter logic [9:0] P_H_BP     = H_BP,
    parameter logic [9:0] P_V_ACTIVE = V_ACTIVE,
    parameter logic [9:0] P_V_FP     = V_FP,
    parameter logic [9:0] P_V_SYNC   = V_SYNC,
    parameter logic [9:0] P_V_BP     = V_BP
) (
    input  logic       pixelclk,
    input  logic       rst,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       visible,
    output logic       frame_end
);

    localparam logic [9:0] H_LAST   = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP - 10'd1;
    localparam logic [9:0] V_LAST   = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP - 10'd1;
    localparam logic [9:0] HS_BEGIN = P_H_ACTIVE + P_H_FP;
    localparam logic [9:0] HS_END   = HS_BEGIN + P_H_SYNC;
    localparam logic [9:0] VS_BEGIN = P_V_ACTIVE + P_V_FP;
    localparam logic [9:0] VS_END   = VS_BEGIN + P_V_SYNC;

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge pixelclk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt      = hcnt_q;
    assign vcnt      = vcnt_q;
    assign hsync_n   = !((hcnt_q >= HS_BEGIN) && (hcnt_q < HS_END));
    assign vsync_n   = !((vcnt_q >= VS_BEGIN) && (vcnt_q < VS_END));
    assign visible   = (hcnt_q < P_H_ACTIVE) && (vcnt_q < P_V_ACTIVE);
    assign frame_end = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

endmodule

// File: rtl/traffic_lite_vga_render.sv
// -----------------------------------------------------------------------------
// traffic_lite_vga_render
// Draws three vertically stacked lamp squares on a VGA raster. Each lamp has a
// white outline; its interior takes the latched colour when its select bit is
// set and stays black otherwise.
// Ports:
//   pixelclk     in   pixel clock
//   rst          in   synchronous active-high reset
//   color_in     in   {r,g,b} lamp colour from the controller
//   squares_in   in   lamp select, bit0 = top, bit2 = bottom (several may be set)
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   rgb          out  {r,g,b} pixel
//   active       out  rgb is a visible pixel
//   frame_start  out  one-cycle pulse with output pixel (0,0)
// All outputs are registered one cycle behind the raster counters. The inputs
// are sampled only on the last raster position, so a frame never tears.
// -----------------------------------------------------------------------------
module traffic_lite_vga_render
    import traffic_vga_pkg::*;
#(
    parameter logic [9:0] P_H_ACTIVE = H_ACTIVE,
    parameter logic [9:0] P_H_FP     = H_FP,
    parameter logic [9:0] P_H_SYNC   = H_SYNC,
    parameter logic [9:0] P_H_BP     = H_BP,
    parameter logic [9:0] P_V_ACTIVE = V_ACTIVE,
    parameter logic [9:0] P_V_FP     = V_FP,
    parameter logic [9:0] P_V_SYNC   = V_SYNC,
    parameter logic [9:0] P_V_BP     = V_BP,
    parameter logic [9:0] P_SQ_X0    = SQ_X0,
    parameter logic [9:0] P_SQ_Y0    = SQ_Y0,
    parameter logic [9:0] P_SQ_SIZE  = SQ_SIZE,
    parameter logic [9:0] P_SQ_GAP   = SQ_GAP,
    parameter logic [9:0] P_BORDER   = BORDER
) (
    input  logic       pixelclk,
    input  logic       rst,
    input  logic [2:0] color_in,
    input  logic [2:0] squares_in,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb,
    output logic       active,
    output logic       frame_start
);

    localparam logic [9:0] X_LO  = P_SQ_X0;
    localparam logic [9:0] X_HI  = P_SQ_X0 + P_SQ_SIZE;
    localparam logic [9:0] XI_LO = X_LO + P_BORDER;
    localparam logic [9:0] XI_HI = X_HI - P_BORDER;

    logic [9:0] hcnt, vcnt;
    logic       hsync_n, vsync_n, visible, frame_end;

    vga_timing_gen #(
        .P_H_ACTIVE (P_H_ACTIVE),
        .P_H_FP     (P_H_FP),
        .P_H_SYNC   (P_H_SYNC),
        .P_H_BP     (P_H_BP),
        .P_V_ACTIVE (P_V_ACTIVE),
        .P_V_FP     (P_V_FP),
        .P_V_SYNC   (P_V_SYNC),
        .P_V_BP     (P_V_BP)
    ) u_timing (
        .pixelclk  (pixelclk),
        .rst       (rst),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n),
        .visible   (visible),
        .frame_end (frame_end)
    );

    // Lamp hit tests: bounds are constants, so each test is a handful of
    // magnitude comparators on the counters.
    logic       in_x_outer, in_x_inner;
    logic [2:0] hit_outer, hit_inner;

    assign in_x_outer = (hcnt >= X_LO)  && (hcnt < X_HI);
    assign in_x_inner = (hcnt >= XI_LO) && (hcnt < XI_HI);

    for (genvar g = 0; g < 3; g++) begin : g_lamp
        localparam logic [9:0] TOP = lamp_top(2'(g), P_SQ_Y0, P_SQ_SIZE, P_SQ_GAP);
        localparam logic [9:0] BOT = TOP + P_SQ_SIZE;
        assign hit_outer[g] = in_x_outer && (vcnt >= TOP) && (vcnt < BOT);
        assign hit_inner[g] = in_x_inner && (vcnt >= TOP + P_BORDER) && (vcnt < BOT - P_BORDER);
    end

    color_t     col_q, col_d;
    logic [2:0] sq_q, sq_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    color_t     rgb_q, rgb_d;
    logic       active_q, active_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        col_d = col_q;
        sq_d  = sq_q;
        if (frame_end) begin
            col_d = color_in;
            sq_d  = squares_in;
        end

        // Lamps never overlap, so an outline hit in any lamp wins and an
        // interior hit can only come from the lamp that owns this pixel.
        rgb_d = C_BLACK;
        if (visible) begin
            if (|(hit_outer & ~hit_inner)) begin
                rgb_d = C_WHITE;
            end else if (|(hit_inner & sq_q)) begin
                rgb_d = col_q;
            end
        end

        hsync_d       = hsync_n;
        vsync_d       = vsync_n;
        active_d      = visible;
        frame_start_d = (hcnt == 10'd0) && (vcnt == 10'd0);
    end

    always_ff @(posedge pixelclk) begin
        if (rst) begin
            col_q         <= C_BLACK;
            sq_q          <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= C_BLACK;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            sq_q          <= sq_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_traffic_lite_vga_render.sv
// -----------------------------------------------------------------------------
// tb_traffic_lite_vga_render
// Bench for traffic_lite_vga_render. The main DUT uses a scaled-down raster so
// whole frames are short; a second DUT with default parameters is checked over
// its first two lines for real 640x480 horizontal timing.
// Scaled raster: 40 visible + 4 fp + 6 sync + 4 bp = 54 clocks per line,
//                38 visible + 2 fp + 2 sync + 3 bp = 45 lines per frame.
// Scaled lamps:  x 14..23, y 2..11 / 14..23 / 26..35, outline 2 pixels.
// -----------------------------------------------------------------------------
module tb_traffic_lite_vga_render;

    localparam int H_ACT = 40, H_FP = 4, H_SY = 6, H_BP = 4;
    localparam int V_ACT = 38, V_FP = 2, V_SY = 2, V_BP = 3;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int X0 = 14, Y0 = 2, SIZE = 10, GAP = 2, BRD = 2;

    logic       pixelclk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] color_in = 3'b000;
    logic [2:0] squares_in = 3'b000;
    logic       hsync, vsync, active, frame_start;
    logic [2:0] rgb;
    logic       d_hsync, d_vsync, d_active, d_frame_start;
    logic [2:0] d_rgb;

    int n_tests = 0;
    int n_fail  = 0;

    always #20 pixelclk = ~pixelclk;

    traffic_lite_vga_render #(
        .P_H_ACTIVE (10'(H_ACT)), .P_H_FP (10'(H_FP)), .P_H_SYNC (10'(H_SY)), .P_H_BP (10'(H_BP)),
        .P_V_ACTIVE (10'(V_ACT)), .P_V_FP (10'(V_FP)), .P_V_SYNC (10'(V_SY)), .P_V_BP (10'(V_BP)),
        .P_SQ_X0 (10'(X0)), .P_SQ_Y0 (10'(Y0)), .P_SQ_SIZE (10'(SIZE)),
        .P_SQ_GAP (10'(GAP)), .P_BORDER (10'(BRD))
    ) dut (
        .pixelclk    (pixelclk),
        .rst         (rst),
        .color_in    (color_in),
        .squares_in  (squares_in),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .active      (active),
        .frame_start (frame_start)
    );

    traffic_lite_vga_render dut_vga (
        .pixelclk    (pixelclk),
        .rst         (rst),
        .color_in    (color_in),
        .squares_in  (squares_in),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .rgb         (d_rgb),
        .active      (d_active),
        .frame_start (d_frame_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference picture: which lamp a row belongs to is found by dividing the
    // offset from the first lamp by the lamp pitch.
    function automatic logic [2:0] model_pix(input int x, input int y,
                                             input logic [2:0] col, input logic [2:0] sq);
        int k, r, cx;
        if (x >= H_ACT || y >= V_ACT) return 3'b000;
        if (x < X0 || x >= X0 + SIZE || y < Y0) return 3'b000;
        k  = (y - Y0) / (SIZE + GAP);
        r  = (y - Y0) % (SIZE + GAP);
        cx = x - X0;
        if (k > 2 || r >= SIZE) return 3'b000;
        if (cx < BRD || cx >= SIZE - BRD || r < BRD || r >= SIZE - BRD) return 3'b111;
        return sq[k] ? col : 3'b000;
    endfunction

    // Model state: raster position the DUT counters hold, latched inputs,
    // expected outputs after this edge, and the pixel those outputs describe.
    int         mx, my, dx, dy;
    logic [2:0] mcol, msq;
    logic [6:0] exp_out;
    logic       model_ok = 1'b0;
    logic       dvalid;
    logic [2:0] fb [V_ACT][H_ACT];

    always @(posedge pixelclk) begin
        if (rst) begin
            mx = 0; my = 0; mcol = 3'b000; msq = 3'b000;
            exp_out  = {1'b1, 1'b1, 3'b000, 1'b0, 1'b0};
            model_ok = 1'b1;
            dvalid   = 1'b0;
        end else begin
            exp_out = { !(mx >= H_ACT + H_FP && mx < H_ACT + H_FP + H_SY),
                        !(my >= V_ACT + V_FP && my < V_ACT + V_FP + V_SY),
                        model_pix(mx, my, mcol, msq),
                        (mx < H_ACT && my < V_ACT),
                        (mx == 0 && my == 0) };
            dx = mx; dy = my; dvalid = 1'b1;
            if (mx == H_TOT - 1 && my == V_TOT - 1) begin
                mcol = color_in;
                msq  = squares_in;
            end
            mx = mx + 1;
            if (mx == H_TOT) begin
                mx = 0;
                my = (my + 1) % V_TOT;
            end
        end
        #1;
        if (model_ok) check("pix", {hsync, vsync, rgb, active, frame_start}, exp_out);
        if (dvalid && dx < H_ACT && dy < V_ACT) fb[dy][dx] = rgb;
    end

    // Waits for the next frame_start (bounded) and tallies the outputs seen on
    // the way, including the cycle carrying the pulse.
    task automatic wait_frame(output int cyc, output int act, output int hs_lo, output int vs_lo);
        cyc = 0; act = 0; hs_lo = 0; vs_lo = 0;
        do begin
            @(posedge pixelclk); #2;
            cyc++;
            if (active) act++;
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
        end while (!frame_start && cyc < 3 * FRAME);
        if (!frame_start) check("frame_timeout", 32'(frame_start), 32'd1);
    endtask

    initial begin
        #(200_000 * 40);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, act, hs_lo, vs_lo;
        int d_act, d_hs, d_hs_first, d_vs, d_lit;

        // Reset with a lamp already requested: the first frame must stay dark.
        color_in = 3'b100; squares_in = 3'b001; rst = 1'b1;
        repeat (3) @(posedge pixelclk);
        #2;
        check("rst_outputs", {hsync, vsync, rgb, active, frame_start}, 7'b11_000_0_0);
        rst = 1'b0;

        wait_frame(cyc, act, hs_lo, vs_lo);
        check("fs_latency_after_rst", cyc, 1);

        wait_frame(cyc, act, hs_lo, vs_lo);
        check("frame1_len", cyc, FRAME);
        check("frame1_lamp0_dark", fb[7][19], 3'b000);
        check("frame1_outline", fb[7][14], 3'b111);

        wait_frame(cyc, act, hs_lo, vs_lo);
        check("frame2_len", cyc, FRAME);
        check("frame2_active", act, H_ACT * V_ACT);
        check("frame2_hsync_low", hs_lo, H_SY * V_TOT);
        check("frame2_vsync_low", vs_lo, V_SY * H_TOT);
        check("red_top", fb[7][19], 3'b100);
        check("red_mid_dark", fb[19][19], 3'b000);
        check("red_top_outline", fb[7][14], 3'b111);

        // Mid-frame change at row 20: must not show until the next frame.
        repeat (20 * H_TOT) @(posedge pixelclk);
        #2;
        color_in = 3'b010; squares_in = 3'b100;
        wait_frame(cyc, act, hs_lo, vs_lo);
        check("no_tear_top", fb[7][19], 3'b100);
        check("no_tear_bottom", fb[31][19], 3'b000);
        color_in = 3'b110; squares_in = 3'b011;
        wait_frame(cyc, act, hs_lo, vs_lo);
        check("green_bottom", fb[31][19], 3'b010);
        check("green_top_dark", fb[7][19], 3'b000);

        wait_frame(cyc, act, hs_lo, vs_lo);
        check("multi_top", fb[7][19], 3'b110);
        check("multi_mid", fb[19][19], 3'b110);
        check("multi_bottom_dark", fb[31][19], 3'b000);

        // Random inputs changed at random points, including right before the
        // latch position; the per-cycle model comparison does the checking.
        for (int f = 0; f < 6; f++) begin
            int k;
            k = (f == 2) ? FRAME - 3 : int'($urandom_range(0, FRAME - H_TOT));
            repeat (k) @(posedge pixelclk);
            #2;
            color_in   = 3'($urandom);
            squares_in = 3'($urandom);
            wait_frame(cyc, act, hs_lo, vs_lo);
        end

        // Mid-frame reset around (30,20), held 3 clocks.
        repeat (20 * H_TOT + 29) @(posedge pixelclk);
        #2;
        color_in = 3'b100; squares_in = 3'b111;
        rst = 1'b1;
        repeat (3) @(posedge pixelclk);
        #2;
        check("midrst_outputs", {hsync, vsync, rgb, active, frame_start}, 7'b11_000_0_0);
        rst = 1'b0;

        // First two lines after reset, both instances.
        d_act = 0; d_hs = 0; d_hs_first = -1; d_vs = 0; d_lit = 0;
        for (int c = 1; c <= 1600; c++) begin
            @(posedge pixelclk); #2;
            if (c == 1) begin
                check("midrst_fs", 32'(frame_start), 32'd1);
                check("vga_fs", 32'(d_frame_start), 32'd1);
            end
            if (d_active) d_act++;
            if (!d_hsync) begin
                d_hs++;
                if (d_hs_first < 0) d_hs_first = c - 1;
            end
            if (!d_vsync) d_vs++;
            if (d_rgb != 3'b000) d_lit++;
        end
        check("vga_active_2lines", d_act, 1280);
        check("vga_hsync_low_2lines", d_hs, 192);
        check("vga_hsync_first", d_hs_first, 656);
        check("vga_vsync_low", d_vs, 0);
        check("vga_rgb_dark", d_lit, 0);

        wait_frame(cyc, act, hs_lo, vs_lo);
        check("postrst_lamp0_dark", fb[7][19], 3'b000);
        check("postrst_lamp2_dark", fb[31][19], 3'b000);
        check("postrst_outline", fb[19][14], 3'b111);
        wait_frame(cyc, act, hs_lo, vs_lo);
        check("all_lamps_top", fb[7][19], 3'b100);
        check("all_lamps_bottom", fb[31][19], 3'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
